spram_arbiter: RTL and testbench

SPRAM_ARBITER -- requirements
Module: spram_arbiter

---
 rtl/fetchie_mem_pkg.sv | 28 ++
 rtl/spram_arbiter.sv | 146 ++++++++++++++
 tb/tb_spram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetchie_mem_pkg.sv
// ---------------------------------------------------------------------------
// fetchie_mem_pkg
// Shared definitions for the fetchie memory subsystem: default SPRAM
// geometry, the arbiter port index type and the SPRAM command bundle used
// by the top level when wiring the arbiter to the ice40up5k_spram instance.
// ---------------------------------------------------------------------------
package fetchie_mem_pkg;

  // Default geometry: 32768 x 16-bit words, one byte enable per byte.
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // Port 0 is the CPU, port 1 is the UART loader.
  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_UART = 1'b1
  } port_id_t;

  // One SPRAM command as seen by the memory macro (default geometry).
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   be;
    logic                  wen;
  } mem_cmd_t;

endpackage

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter
// Two-port arbiter in front of a single-port SPRAM. Port 0 (CPU) has
// priority, but port 1 (UART loader) is guaranteed a grant after waiting
// STARVE_LIMIT consecutive cycles. Grants are combinational so one access
// per cycle is sustained; read data returns one cycle after the grant on
// the port that issued it.
//
// Ports:
//   CLK, RESET_N              clock, synchronous active-low reset
//   pN_req/we/addr/wdata/be   request from port N (held until granted)
//   pN_gnt                    request accepted this cycle
//   pN_rvalid/pN_rdata        read response, one cycle after grant
//   mem_addr/wdata/be/wen     SPRAM command
//   mem_rdata                 SPRAM read data (one cycle latency)
// ---------------------------------------------------------------------------
module spram_arbiter
  import fetchie_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_be,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_be,
  output logic                p0_gnt,
  output logic                p1_gnt,
  output logic                p0_rvalid,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_wen,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
  logic                respValid_q, respValid_d;
  port_id_t            respPort_q, respPort_d;
  logic [ADDR_W-1:0]   addrHold_q, addrHold_d;
  logic [DATA_W-1:0]   wdataHold_q, wdataHold_d;

  logic                grant0, grant1, granted;
  logic                selWe;
  logic [ADDR_W-1:0]   selAddr;
  logic [DATA_W-1:0]   selWdata;
  logic [BE_W-1:0]     selBe;

  // Grant decision. Nothing is granted while reset is held. When both
  // ports ask, port 1 only wins once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (RESET_N) begin
      if (p0_req && p1_req) begin
        if (starveCnt_q == STARVE_MAX) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = p0_req;
        grant1 = p1_req;
      end
    end
  end

  assign p0_gnt  = grant0;
  assign p1_gnt  = grant1;
  assign granted = grant0 | grant1;

  // Steer the winning port onto the SPRAM command. Address and write data
  // hold their last driven value when idle so the macro inputs stay quiet.
  always_comb begin
    selWe    = grant1 ? p1_we    : p0_we;
    selAddr  = grant1 ? p1_addr  : p0_addr;
    selWdata = grant1 ? p1_wdata : p0_wdata;
    selBe    = grant1 ? p1_be    : p0_be;

    mem_addr  = granted ? selAddr  : addrHold_q;
    mem_wdata = granted ? selWdata : wdataHold_q;
    mem_be    = granted ? selBe    : '0;
    mem_wen   = granted & selWe;
  end

  // Next-state: starvation counter tracks consecutive cycles port 1 has
  // been refused; the read tracker remembers which port owns next cycle's
  // mem_rdata.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!p1_req || grant1) begin
      starveCnt_d = '0;
    end else if (starveCnt_q != STARVE_MAX) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end

    respValid_d = granted & ~selWe;
    respPort_d  = respPort_q;
    if (granted && !selWe) begin
      respPort_d = grant1 ? PORT_UART : PORT_CPU;
    end

    addrHold_d  = mem_addr;
    wdataHold_d = mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      starveCnt_q <= '0;
      respValid_q <= 1'b0;
      respPort_q  <= PORT_CPU;
      addrHold_q  <= '0;
      wdataHold_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      respValid_q <= respValid_d;
      respPort_q  <= respPort_d;
      addrHold_q  <= addrHold_d;
      wdataHold_q <= wdataHold_d;
    end
  end

  // Responses are suppressed during reset so a read granted just before
  // reset never surfaces.
  assign p0_rvalid = RESET_N & respValid_q & (respPort_q == PORT_CPU);
  assign p1_rvalid = RESET_N & respValid_q & (respPort_q == PORT_UART);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spram_arbiter
// Directed scenarios followed by randomized traffic against spram_arbiter,
// with a behavioural SPRAM model driving mem_rdata and a reference model of
// the arbitration and memory contents checking every cycle.
// ---------------------------------------------------------------------------
module tb_spram_arbiter;

  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 16;
  localparam int BE_W         = 2;
  localparam int STARVE_LIMIT = 4;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic [BE_W-1:0]   p0_be, p1_be;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_wen;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  spram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  // Power-on memory image; a few addresses carry the values the directed
  // scenarios rely on.
  function automatic logic [15:0] initVal(input logic [14:0] a);
    if (a == 15'h0010) return 16'hBEEF;
    if (a == 15'h7FFF) return 16'hAAAA;
    return (16'(a) * 16'h9E37) + 16'h1357;
  endfunction

  function automatic logic [15:0] mergeBytes(input logic [15:0] old, input logic [15:0] nw,
                                             input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  // Behavioural SPRAM: write with byte enables, registered read every cycle.
  logic [15:0] sramStore   [0:32767];
  bit          sramWritten [0:32767];

  function automatic logic [15:0] sramRead(input logic [14:0] a);
    return sramWritten[a] ? sramStore[a] : initVal(a);
  endfunction

  always @(posedge CLK) begin
    if (mem_wen) begin
      sramStore[mem_addr]   <= mergeBytes(sramRead(mem_addr), mem_wdata, mem_be);
      sramWritten[mem_addr] <= 1'b1;
    end
    mem_rdata <= sramRead(mem_addr);
  end

  // Reference model: expected memory image, consecutive losses of port 1,
  // last driven command fields and the list of outstanding read responses.
  typedef struct {
    int          port;
    logic [15:0] data;
  } resp_t;

  logic [15:0] refMem     [0:32767];
  bit          refWritten [0:32767];
  int          p1Losses     = 0;
  logic [14:0] expHoldAddr  = '0;
  logic [15:0] expHoldWdata = '0;
  resp_t       respQ[$];
  logic        expG0, expG1;

  logic        snapG0, snapG1, snapRv0, snapRv1;
  logic [15:0] snapRd0, snapRd1;

  function automatic logic [15:0] refRead(input logic [14:0] a);
    return refWritten[a] ? refMem[a] : initVal(a);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [14:0] addr, input logic [15:0] wdata,
                               input logic [1:0] be);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic checkOutput();
    logic        inReset, anyG, gWe;
    logic [14:0] eAddr;
    logic [15:0] eWdata, eRd0, eRd1;
    logic [1:0]  eBe;
    logic        eRv0, eRv1;
    inReset = !RESET_N;
    expG0 = 1'b0;
    expG1 = 1'b0;
    if (!inReset) begin
      if (p0_req && p1_req) begin
        if (p1Losses >= STARVE_LIMIT) expG1 = 1'b1;
        else expG0 = 1'b1;
      end else begin
        expG0 = p0_req;
        expG1 = p1_req;
      end
    end
    anyG   = expG0 | expG1;
    gWe    = expG1 ? p1_we : p0_we;
    eAddr  = anyG ? (expG1 ? p1_addr : p0_addr) : expHoldAddr;
    eWdata = anyG ? (expG1 ? p1_wdata : p0_wdata) : expHoldWdata;
    eBe    = anyG ? (expG1 ? p1_be : p0_be) : 2'b00;
    eRv0 = 1'b0; eRv1 = 1'b0; eRd0 = '0; eRd1 = '0;
    if (!inReset && respQ.size() > 0) begin
      if (respQ[0].port == 0) begin eRv0 = 1'b1; eRd0 = respQ[0].data; end
      else begin eRv1 = 1'b1; eRd1 = respQ[0].data; end
    end
    checkVal("p0_gnt", 32'(p0_gnt), 32'(expG0));
    checkVal("p1_gnt", 32'(p1_gnt), 32'(expG1));
    checkVal("mem_wen", 32'(mem_wen), 32'(anyG & gWe));
    checkVal("mem_be", 32'(mem_be), 32'(eBe));
    checkVal("mem_addr", 32'(mem_addr), 32'(eAddr));
    checkVal("mem_wdata", 32'(mem_wdata), 32'(eWdata));
    checkVal("p0_rvalid", 32'(p0_rvalid), 32'(eRv0));
    checkVal("p1_rvalid", 32'(p1_rvalid), 32'(eRv1));
    checkVal("p0_rdata", 32'(p0_rdata), 32'(eRd0));
    checkVal("p1_rdata", 32'(p1_rdata), 32'(eRd1));
    snapG0 = p0_gnt; snapG1 = p1_gnt; snapRv0 = p0_rvalid; snapRv1 = p1_rvalid;
    snapRd0 = p0_rdata; snapRd1 = p1_rdata;
  endtask

  // Advance the reference model across the coming clock edge.
  task automatic updateModel();
    logic        we;
    logic [14:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    respQ.delete();
    if (!RESET_N) begin
      p1Losses     = 0;
      expHoldAddr  = '0;
      expHoldWdata = '0;
      return;
    end
    if (p1_req && !expG1) p1Losses = (p1Losses < STARVE_LIMIT) ? p1Losses + 1 : p1Losses;
    else p1Losses = 0;
    if (expG0 || expG1) begin
      we = expG1 ? p1_we : p0_we;
      a  = expG1 ? p1_addr : p0_addr;
      d  = expG1 ? p1_wdata : p0_wdata;
      be = expG1 ? p1_be : p0_be;
      expHoldAddr  = a;
      expHoldWdata = d;
      if (we) begin
        refMem[a]     = mergeBytes(refRead(a), d, be);
        refWritten[a] = 1'b1;
      end else begin
        respQ.push_back('{port: (expG1 ? 1 : 0), data: refRead(a)});
      end
    end
  endtask

  task automatic runCycle();
    @(negedge CLK);
    checkOutput();
    updateModel();
    @(posedge CLK);
    #1;
  endtask

  task automatic idlePorts();
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  typedef struct {
    logic        active;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } rq_t;

  initial begin
    logic [9:0] pattern;
    rq_t        rq [2];

    // Reset and idle state.
    RESET_N = 1'b0;
    idlePorts();
    runCycle();
    runCycle();
    checkVal("reset_gnt", 32'({snapG0, snapG1}), 32'h0);
    RESET_N = 1'b1;
    runCycle();

    // Lone CPU read returns 0xBEEF on port 0 only.
    applyStimulus(0, 1'b1, 1'b0, 15'h0010, 16'h0, 2'b00);
    runCycle();
    checkVal("p0_read_gnt", 32'(snapG0), 32'h1);
    idlePorts();
    runCycle();
    checkVal("p0_read_rvalid", 32'(snapRv0), 32'h1);
    checkVal("p0_read_data", 32'(snapRd0), 32'hBEEF);
    checkVal("p0_read_p1_quiet", 32'(snapRv1), 32'h0);

    // Byte-merged write followed immediately by a read.
    applyStimulus(1, 1'b1, 1'b1, 15'h7FFF, 16'h1234, 2'b01);
    runCycle();
    checkVal("p1_write_gnt", 32'(snapG1), 32'h1);
    idlePorts();
    applyStimulus(0, 1'b1, 1'b0, 15'h7FFF, 16'h0, 2'b00);
    runCycle();
    checkVal("write_no_rvalid", 32'({snapRv0, snapRv1}), 32'h0);
    idlePorts();
    runCycle();
    checkVal("merge_data", 32'(snapRd0), 32'hAA34);

    // Alternating ports, each response lands on its own port.
    applyStimulus(0, 1'b1, 1'b0, 15'h0001, 16'h0, 2'b00);
    runCycle();
    idlePorts();
    applyStimulus(1, 1'b1, 1'b0, 15'h0002, 16'h0, 2'b00);
    runCycle();
    checkVal("alt_rv_a", 32'({snapRv0, snapRv1}), 32'h2);
    checkVal("alt_rd_a", 32'(snapRd0), 32'(initVal(15'h0001)));
    idlePorts();
    runCycle();
    checkVal("alt_rv_b", 32'({snapRv0, snapRv1}), 32'h1);
    checkVal("alt_rd_b", 32'(snapRd1), 32'(initVal(15'h0002)));

    // Both ports reading continuously: port 1 wins every fifth cycle.
    applyStimulus(0, 1'b1, 1'b0, 15'h0020, 16'h0, 2'b00);
    applyStimulus(1, 1'b1, 1'b0, 15'h0021, 16'h0, 2'b00);
    pattern = '0;
    for (int i = 0; i < 10; i++) begin
      runCycle();
      pattern[i] = snapG1;
    end
    checkVal("starve_pattern", 32'(pattern), 32'h210);

    // Port 1 gives up after three losses and comes back.
    idlePorts();
    runCycle();
    applyStimulus(0, 1'b1, 1'b0, 15'h0030, 16'h0, 2'b00);
    applyStimulus(1, 1'b1, 1'b0, 15'h0031, 16'h0, 2'b00);
    pattern = '0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) applyStimulus(1, 1'b0, 1'b0, 15'h0031, 16'h0, 2'b00);
      if (i == 4) applyStimulus(1, 1'b1, 1'b0, 15'h0031, 16'h0, 2'b00);
      runCycle();
      pattern[i] = snapG1;
    end
    checkVal("restart_pattern", 32'(pattern), 32'h100);

    // Reset right after a port 1 read grant drops its response.
    idlePorts();
    runCycle();
    applyStimulus(1, 1'b1, 1'b0, 15'h0040, 16'h0, 2'b00);
    runCycle();
    checkVal("pre_reset_gnt", 32'(snapG1), 32'h1);
    RESET_N = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 15'h0041, 16'h0, 2'b00);
    runCycle();
    checkVal("reset_gnt_mid", 32'({snapG0, snapG1}), 32'h0);
    checkVal("reset_rvalid", 32'(snapRv1), 32'h0);
    RESET_N = 1'b1;
    idlePorts();
    runCycle();
    checkVal("post_reset_rvalid", 32'({snapRv0, snapRv1}), 32'h0);

    // Reset clears accumulated starvation.
    applyStimulus(0, 1'b1, 1'b0, 15'h0050, 16'h0, 2'b00);
    applyStimulus(1, 1'b1, 1'b0, 15'h0051, 16'h0, 2'b00);
    runCycle();
    runCycle();
    runCycle();
    RESET_N = 1'b0;
    runCycle();
    runCycle();
    RESET_N = 1'b1;
    pattern = '0;
    for (int i = 0; i < 5; i++) begin
      runCycle();
      pattern[i] = snapG1;
    end
    checkVal("reset_starve_clear", 32'(pattern), 32'h10);

    // Randomized traffic with occasional resets, requests held until granted.
    idlePorts();
    rq[0] = '{active: 1'b0, we: 1'b0, addr: '0, wdata: '0, be: '0};
    rq[1] = rq[0];
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p].active && $urandom_range(0, 2) != 0) begin
          rq[p].active = 1'b1;
          rq[p].we     = 1'($urandom_range(0, 1));
          rq[p].addr   = 15'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 15'h7FF8 : 15'h0);
          rq[p].wdata  = 16'($urandom);
          rq[p].be     = 2'($urandom_range(0, 3));
        end
        applyStimulus(p, rq[p].active, rq[p].we, rq[p].addr, rq[p].wdata, rq[p].be);
      end
      RESET_N = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      runCycle();
      if (snapG0) rq[0].active = 1'b0;
      if (snapG1) rq[1].active = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
